// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state names, opcodes,
// branch condition codes, R-type extension codes, ALU op codes and flag bit
// positions, plus helpers that map an immediate opcode to its ALU op.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Opcodes, ir[15:12]
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_SUBI  = 4'h2;
    localparam logic [3:0] OP_CMPI  = 4'h3;
    localparam logic [3:0] OP_ANDI  = 4'h4;
    localparam logic [3:0] OP_ORI   = 4'h5;
    localparam logic [3:0] OP_XORI  = 4'h6;
    localparam logic [3:0] OP_MOVI  = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STOR  = 4'h9;
    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Branch condition codes, ir[11:8] of Bcond
    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_GT = 4'h4;
    localparam logic [3:0] CC_LE = 4'h5;
    localparam logic [3:0] CC_FS = 4'h6;
    localparam logic [3:0] CC_FC = 4'h7;
    localparam logic [3:0] CC_LO = 4'h8;
    localparam logic [3:0] CC_HS = 4'h9;
    localparam logic [3:0] CC_UC = 4'hE;

    // R-type extension codes, ir[3:0]; the ALU op is {4'h0, ext}
    localparam logic [3:0] EXT_AND  = 4'h1;
    localparam logic [3:0] EXT_OR   = 4'h2;
    localparam logic [3:0] EXT_XOR  = 4'h3;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_ADDC = 4'h6;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_CMP  = 4'hB;
    localparam logic [3:0] EXT_MOV  = 4'hD;

    localparam logic [7:0] ALU_AND = {4'h0, EXT_AND};
    localparam logic [7:0] ALU_OR  = {4'h0, EXT_OR};
    localparam logic [7:0] ALU_XOR = {4'h0, EXT_XOR};
    localparam logic [7:0] ALU_ADD = {4'h0, EXT_ADD};
    localparam logic [7:0] ALU_SUB = {4'h0, EXT_SUB};
    localparam logic [7:0] ALU_CMP = {4'h0, EXT_CMP};
    localparam logic [7:0] ALU_MOV = {4'h0, EXT_MOV};

    // Flag register bit positions, flags = {C,L,F,Z,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    function automatic logic [7:0] imm_alu_op(input logic [3:0] op);
        case (op)
            OP_ADDI: return ALU_ADD;
            OP_SUBI: return ALU_SUB;
            OP_CMPI: return ALU_CMP;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_XORI: return ALU_XOR;
            OP_MOVI: return ALU_MOV;
            default: return 8'h00;
        endcase
    endfunction

    // Arithmetic immediates are signed; logical and move immediates are not.
    function automatic logic imm_is_signed(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator, purely combinational.
// Ports: cond (ir[11:8] of a Bcond), flags {C,L,F,Z,N}; taken = branch is taken.
// Codes 0xA-0xD and 0xF never branch; 0xE always branches.
module cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken =  flags[FLAG_Z];
            CC_NE:   taken = !flags[FLAG_Z];
            CC_CS:   taken =  flags[FLAG_C];
            CC_CC:   taken = !flags[FLAG_C];
            CC_GT:   taken =  flags[FLAG_N];
            CC_LE:   taken = !flags[FLAG_N];
            CC_FS:   taken =  flags[FLAG_F];
            CC_FC:   taken = !flags[FLAG_F];
            CC_LO:   taken =  flags[FLAG_L];
            CC_HS:   taken = !flags[FLAG_L];
            CC_UC:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU controller: FETCH -> DECODE -> EXEC (-> MEM for LOAD), HALT.
// Inputs: clk, sync active-high reset, instr (bram data, one cycle after
// mem_addr), flags {C,L,F,Z,N}, addr_data (A-mux output for load/store address).
// Outputs: bram address/write enable, register-file selects, ALU control,
// bus drive enables, halted. Strobes depend only on state and ir.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic [4:0]  flags,
    input  logic [15:0] addr_data,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  a_sel,
    output logic [3:0]  b_sel,
    output logic        imm_sel,
    output logic [15:0] imm,
    output logic [7:0]  alu_op,
    output logic        cin,
    output logic        flags_en,
    output logic        reg_write,
    output logic [3:0]  reg_dest,
    output logic        alu_drive,
    output logic        mem_drive,
    output logic        halted
);

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] ir;

    logic [3:0]  opcode;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [3:0]  ext;
    logic [7:0]  imm8;
    logic [15:0] imm_sext;
    logic [15:0] pc_inc;
    logic [15:0] pc_branch;
    logic        br_taken;

    assign opcode    = ir[15:12];
    assign rdest     = ir[11:8];
    assign rsrc      = ir[7:4];
    assign ext       = ir[3:0];
    assign imm8      = ir[7:0];
    assign imm_sext  = {{8{imm8[7]}}, imm8};
    // 16-bit adds wrap naturally, so a backward branch from low pc lands high.
    assign pc_inc    = pc + 16'd1;
    assign pc_branch = pc + imm_sext;

    cond_eval u_cond_eval (
        .cond  (rdest),
        .flags (flags),
        .taken (br_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            // bram data for the FETCH address is valid during DECODE
            if (state == ST_DECODE) begin
                ir <= instr;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        mem_addr   = pc;
        mem_we     = 1'b0;
        a_sel      = rdest;
        b_sel      = rsrc;
        imm_sel    = 1'b0;
        imm        = imm_is_signed(opcode) ? imm_sext : {8'h00, imm8};
        alu_op     = 8'h00;
        cin        = 1'b0;
        flags_en   = 1'b0;
        reg_write  = 1'b0;
        reg_dest   = rdest;
        alu_drive  = 1'b0;
        mem_drive  = 1'b0;
        halted     = 1'b0;

        case (state)
            ST_FETCH: begin
                state_next = ST_DECODE;
            end

            ST_DECODE: begin
                state_next = ST_EXEC;
            end

            ST_EXEC: begin
                state_next = ST_FETCH;
                pc_next    = pc_inc;
                case (opcode)
                    OP_RTYPE: begin
                        alu_op    = {4'h0, ext};
                        alu_drive = 1'b1;
                        flags_en  = 1'b1;
                        // CMP only updates flags
                        reg_write = (ext != EXT_CMP);
                        cin       = (ext == EXT_ADDC) ? flags[FLAG_C] : 1'b0;
                    end
                    OP_ADDI, OP_SUBI, OP_CMPI, OP_ANDI,
                    OP_ORI, OP_XORI, OP_MOVI: begin
                        imm_sel   = 1'b1;
                        alu_op    = imm_alu_op(opcode);
                        alu_drive = 1'b1;
                        flags_en  = 1'b1;
                        reg_write = (opcode != OP_CMPI);
                    end
                    OP_LOAD: begin
                        a_sel      = rsrc;
                        mem_addr   = addr_data;
                        pc_next    = pc;
                        state_next = ST_MEM;
                    end
                    OP_STOR: begin
                        a_sel    = rdest;
                        b_sel    = rsrc;
                        mem_addr = addr_data;
                        mem_we   = 1'b1;
                    end
                    OP_BCOND: begin
                        if (br_taken) begin
                            pc_next = pc_branch;
                        end
                    end
                    OP_HALT: begin
                        pc_next    = pc;
                        state_next = ST_HALT;
                    end
                    default: begin
                        // unassigned opcodes behave as NOP
                    end
                endcase
            end

            ST_MEM: begin
                // bram read data is on the bus; write it into rdest
                mem_drive  = 1'b1;
                reg_write  = 1'b1;
                reg_dest   = rdest;
                pc_next    = pc_inc;
                state_next = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

endmodule
